// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch FSM encoding.
package cpu_pkg;

  localparam int ADDR_W_DFLT  = 8;
  localparam int INSTR_W_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_ir.sv
// Width-parameterised register with synchronous active-low reset and load enable.
module fetch_ir #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, reads imem over req/ack and offers
// the fetched word to decode over valid/ready, squashing wrong-path reads.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int INSTR_W = INSTR_W_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_enable,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_value,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  fetch_state_e       state_q;
  logic               squash_q;
  logic [ADDR_W-1:0]  fetch_addr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [INSTR_W-1:0] instr_data_q;

  logic in_req;
  logic ack_ok;
  logic handshake;
  logic idle_go;
  logic hold_go;
  logic fetch_addr_load;

  assign in_req          = (state_q == REQ);
  assign instr_valid     = (state_q == HOLD) && !redirect_valid;
  assign handshake       = instr_valid && instr_ready;
  // A read is only kept if no redirect is pending or arriving with the ack.
  assign ack_ok          = in_req && imem_ack && !squash_q && !redirect_valid;
  assign idle_go         = (state_q == IDLE) && !halt && !redirect_valid;
  assign hold_go         = handshake && !halt;
  assign fetch_addr_load = idle_go || hold_go;

  assign pc_enable     = ack_ok;
  assign pc_load       = redirect_valid;
  assign pc_load_value = redirect_target;
  assign imem_req      = in_req;
  assign imem_addr     = in_req ? fetch_addr_q : '0;
  assign instr_data    = instr_data_q;
  assign instr_pc      = instr_pc_q;

  fetch_ir #(.W(ADDR_W)) u_fetch_addr (
    .clk   (clk),
    .reset (reset),
    .load  (fetch_addr_load),
    .d     (pc_in),
    .q     (fetch_addr_q)
  );

  fetch_ir #(.W(ADDR_W)) u_instr_pc (
    .clk   (clk),
    .reset (reset),
    .load  (ack_ok),
    .d     (fetch_addr_q),
    .q     (instr_pc_q)
  );

  fetch_ir #(.W(INSTR_W)) u_instr_data (
    .clk   (clk),
    .reset (reset),
    .load  (ack_ok),
    .d     (imem_rdata),
    .q     (instr_data_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_go) state_q <= REQ;
        end
        REQ: begin
          // The outstanding read always runs to its ack; a redirect only marks it.
          if (imem_ack) begin
            squash_q <= 1'b0;
            state_q  <= ack_ok ? HOLD : IDLE;
          end else if (redirect_valid) begin
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            state_q <= IDLE;
          end else if (handshake) begin
            state_q <= halt ? IDLE : REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC and memory models plus an
// expected-instruction scoreboard compared at each decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic        pc_enable, pc_load;
  logic [7:0]  pc_load_value;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halt;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid, instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_count = 0;
  int   en_count = 0;
  int   ld_count = 0;
  int   req_count = 0;
  int   cyc = 0;
  int   lat = 0;
  int   mcnt = 0;
  logic man_ack = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc),
    .pc_enable       (pc_enable),
    .pc_load         (pc_load),
    .pc_load_value   (pc_load_value),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_instr(input logic [7:0] a);
    exp_t e;
    e.pc   = a;
    e.data = 16'hA000 + {8'h00, a};
    sb.push_back(e);
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 60; i++) begin
      if (hs_count >= n) break;
      @(negedge clk);
    end
    check("hs_count", hs_count, n);
  endtask

  // Memory: ack after 'lat' wait cycles, data = 0xA000 + address.
  always begin
    @(negedge clk);
    #1;
    if (man_ack) begin
      imem_ack = 1'b1;
    end else if (!imem_req) begin
      mcnt     = 0;
      imem_ack = 1'b0;
    end else begin
      imem_ack = (mcnt == lat);
      mcnt++;
    end
    imem_rdata = 16'hA000 + {8'h00, imem_addr};
  end

  // Monitor samples just before each rising edge; PC model updates just after it.
  logic       s_en, s_ld, s_rst, prev_req, prev_ack;
  logic [7:0] s_ldv, prev_addr;
  initial begin
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; pc = '0;
  end
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    cyc++;
    s_en = pc_enable; s_ld = pc_load; s_ldv = pc_load_value; s_rst = reset;
    if (pc_enable) en_count++;
    if (pc_load) ld_count++;
    if (imem_req) req_count++;
    if (imem_req && prev_req && !prev_ack) check("addr_stable", imem_addr, prev_addr);
    prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    if (instr_valid && instr_ready) begin
      $display("instr pc=%02h data=%04h cycle=%0d", instr_pc, instr_data, cyc);
      hs_cyc.push_back(cyc);
      hs_count++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr_data", instr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    if (!s_rst) pc = '0;
    else if (s_ld) pc = s_ldv;
    else if (s_en) pc = pc + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int b, eb, lb, rb;
    reset = 1'b0; halt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc_en", pc_enable, 0);
    check("rst_pc_ld", pc_load, 0);
    check("rst_data", instr_data, 0);
    check("rst_ipc", instr_pc, 0);

    // Zero-wait streaming from 0x00
    @(negedge clk);
    reset = 1'b1; halt = 1'b0; lat = 0;
    b = hs_count; eb = en_count;
    expect_instr(8'h00); expect_instr(8'h01); expect_instr(8'h02);
    wait_hs(b + 2);
    halt = 1'b1;
    wait_hs(b + 3);
    check("spacing01", hs_cyc[b+1] - hs_cyc[b], 2);
    check("spacing12", hs_cyc[b+2] - hs_cyc[b+1], 2);
    check("stream_en", en_count - eb, 3);
    repeat (2) @(negedge clk);
    #3;
    check("halt_idle_req", imem_req, 0);
    check("halt_idle_valid", instr_valid, 0);

    // 3-cycle ack latency
    @(negedge clk);
    lat = 2; halt = 1'b0;
    b = hs_count; eb = en_count; rb = req_count;
    expect_instr(8'h03);
    @(negedge clk);
    halt = 1'b1;
    wait_hs(b + 1);
    check("lat_req_cycles", req_count - rb, 3);
    check("lat_en", en_count - eb, 1);

    // Decode back-pressure in HOLD
    @(negedge clk);
    lat = 0; instr_ready = 1'b0; halt = 1'b0;
    b = hs_count; rb = req_count;
    expect_instr(8'h04);
    @(negedge clk);
    halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (instr_valid) break;
    end
    check("bp_valid_seen", instr_valid, 1);
    rb = req_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("bp_valid", instr_valid, 1);
      check("bp_data", instr_data, 16'hA004);
      check("bp_pc", instr_pc, 8'h04);
      check("bp_no_req", imem_req, 0);
    end
    check("bp_req_count", req_count - rb, 0);
    @(negedge clk);
    instr_ready = 1'b1;
    wait_hs(b + 1);

    // Redirect to 0x20 during REQ, ack two cycles later
    @(negedge clk);
    lat = 2; halt = 1'b0;
    b = hs_count; eb = en_count; lb = ld_count;
    expect_instr(8'h20);
    @(negedge clk);
    halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h20;
    #3;
    check("rd_req", imem_req, 1);
    check("rd_pc_load", pc_load, 1);
    check("rd_load_val", pc_load_value, 8'h20);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (!imem_req) break;
    end
    check("rd_req_done", imem_req, 0);
    check("rd_no_en", en_count - eb, 0);
    check("rd_one_load", ld_count - lb, 1);
    @(negedge clk);
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    wait_hs(b + 1);
    check("rd_en_after", en_count - eb, 1);

    // Redirect to 0x90 while HOLD with ready=1
    @(negedge clk);
    lat = 0; halt = 1'b0;
    b = hs_count; eb = en_count;
    expect_instr(8'h90);
    @(negedge clk);
    #3;
    check("h_req", imem_req, 1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 8'h90;
    #3;
    check("h_ipc", instr_pc, 8'h21);
    check("h_valid_drop", instr_valid, 0);
    check("h_pc_load", pc_load, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    wait_hs(b + 1);
    check("h_en", en_count - eb, 2);

    // Wrap 0xFF -> 0x00
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 8'hFF;
    b = hs_count;
    expect_instr(8'hFF); expect_instr(8'h00);
    @(negedge clk);
    redirect_valid = 1'b0; halt = 1'b0;
    wait_hs(b + 1);
    halt = 1'b1;
    wait_hs(b + 2);

    // Reset in the middle of a read; the late ack must be ignored
    repeat (2) @(negedge clk);
    lat = 5; halt = 1'b0;
    b = hs_count; eb = en_count;
    @(negedge clk);
    halt = 1'b1;
    #3;
    check("mr_req", imem_req, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; man_ack = 1'b1;
    #3;
    check("mr_req0", imem_req, 0);
    check("mr_addr0", imem_addr, 0);
    check("mr_valid0", instr_valid, 0);
    check("mr_en0", pc_enable, 0);
    check("mr_ld0", pc_load, 0);
    check("mr_data0", instr_data, 0);
    check("mr_ipc0", instr_pc, 0);
    @(negedge clk);
    man_ack = 1'b0;
    #3;
    check("mr_late_req", imem_req, 0);
    check("mr_late_valid", instr_valid, 0);
    check("mr_late_en", en_count - eb, 0);
    check("mr_late_hs", hs_count - b, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of `pc`. Consumes `pc_out`, issues one read per instruction to instruction memory over a req/ack handshake, holds the returned word in an instruction register and offers it to decode over valid/ready. Drives the PC's `enable` (advance after each fetch) and `load`/`load_value` (redirect from execute), with squashing of wrong-path fetches.

## Interface
- `ADDR_W`, 8, PC / instruction-memory address width
- `INSTR_W`, 16, instruction word width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `pc_in`  in  ADDR_W  current PC (from `pc.pc_out`)
- `pc_enable`  out  1  to `pc.enable`; one-cycle pulse per accepted fetch
- `pc_load`  out  1  to `pc.load`
- `pc_load_value`  out  ADDR_W  to `pc.load_value`
- `redirect_valid`  in  1  branch/jump taken in execute
- `redirect_target`  in  ADDR_W  redirect address
- `halt`  in  1  stop launching new fetches
- `imem_req`  out  1  read request, held until ack
- `imem_addr`  out  ADDR_W  read address, stable while `imem_req`=1
- `imem_ack`  in  1  read data valid this cycle
- `imem_rdata`  in  INSTR_W  read data
- `instr_valid`  out  1  instruction offered to decode
- `instr_ready`  in  1  decode accepts
- `instr_data`  out  INSTR_W  instruction register
- `instr_pc`  out  ADDR_W  address of `instr_data`

## Operation
- States: IDLE, REQ, HOLD. Registers: `fetch_addr`, `instr_data`, `instr_pc`, `squash`.
- Reset (`reset`=0 at an edge): state IDLE, `squash`=0, `fetch_addr`/`instr_data`/`instr_pc`=0. All outputs 0 in IDLE with no redirect.
- IDLE: if `halt`=0 and `redirect_valid`=0 -> REQ, `fetch_addr`<=`pc_in`. Otherwise stay.
- REQ: `imem_req`=1, `imem_addr`=`fetch_addr`. On `imem_ack` with `squash`=0 and `redirect_valid`=0: `instr_data`<=`imem_rdata`, `instr_pc`<=`fetch_addr`, `pc_enable`=1 (combinational, same cycle), -> HOLD. On `imem_ack` with `squash`=1 or `redirect_valid`=1: data discarded, no `pc_enable`, `squash`<=0, -> IDLE. Redirect without ack: `squash`<=1, stay REQ (outstanding read is always completed, never abandoned).
- HOLD: `instr_valid` = (state==HOLD) && !`redirect_valid`. On valid&&ready: if `halt`=0 -> REQ, `fetch_addr`<=`pc_in`; else -> IDLE. On redirect: held instruction dropped, -> IDLE.
- Redirect (any state): `pc_load`=`redirect_valid`, `pc_load_value`=`redirect_target`, combinational pass-through. PC load priority over enable resolves simultaneous assertion in the PC.
- `halt` is sampled only when leaving IDLE or HOLD; a fetch in REQ always completes.
- `imem_ack` outside REQ is ignored.
- Address wrap 0xFF->0x00 is performed by the PC; fetch unit follows `pc_in` with no special case.

## Timing
- Zero-wait memory (ack in first REQ cycle), `instr_ready`=1: IDLE->REQ->HOLD->REQ...; first `instr_valid` 2 cycles after leaving IDLE; steady throughput one instruction per 2 cycles.
- `pc_enable` coincides with the accepting ack edge; `pc_in` is already PC+1 when HOLD next enters REQ.
- Redirect latency: `pc_load` same cycle; new target fetched from IDLE on the following cycle (REQ two cycles after redirect), or after the squashed ack completes if redirect hit REQ.
- Reset mid-REQ: state IDLE immediately; any later `imem_ack` ignored.

## Structure
- Shared `cpu_pkg`: `ADDR_W`, `INSTR_W` defaults and the fetch state encoding (IDLE=2'b00, REQ=2'b01, HOLD=2'b10).
- One sub-module: `fetch_ir`, a width-parameterised register with synchronous active-low reset and load enable, instantiated for `instr_data`, `instr_pc`, `fetch_addr`.

## Test plan
- Reset then `pc_in`=0x00, zero-wait memory returning 0xA000+addr, ready=1 -> instr (00,A000),(01,A001),(02,A002) every 2 cycles; `pc_enable` pulses once each.
- Memory with 3-cycle ack latency -> `imem_req` high 3 cycles, `imem_addr` stable, single `pc_enable`, correct data captured.
- `instr_ready`=0 for 4 cycles in HOLD -> `instr_valid`, `instr_data`, `instr_pc` stable, no new `imem_req`.
- Redirect to 0x20 during REQ, ack 2 cycles later -> `pc_load`=1 for one cycle with 0x20, acked data not presented, no `pc_enable`, next fetch at 0x20.
- Redirect to 0x90 while HOLD and ready=1 -> `instr_valid`=0 that cycle, next instr_pc=0x90; then `pc_in`=0xFF fetch followed by 0x00.
- `halt`=1 in HOLD -> after handshake state IDLE, no requests; `reset`=0 mid-REQ -> all outputs 0 next cycle, late ack ignored.
